fm_stereo_nco_gen: RTL and testbench

//  Phase-coherent 38 kHz subcarrier / 19 kHz pilot generator for the FM stereo multiplexer.
//  A single phase accumulator drives both tones, so the 19 kHz pilot is exactly half the
//  38 kHz rate and stays phase-locked to it. Provides square outputs and signed sine samples.

---
 rtl/fm_stereo_nco_gen.sv | 219 +++++++++++++++++++++
 tb/tb_fm_stereo_nco_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_stereo_nco_gen.sv
// -----------------------------------------------------------------------------
// fm_stereo_nco_gen
//
// Phase-coherent 38 kHz subcarrier / 19 kHz pilot generator for the FM stereo
// multiplexer. One phase accumulator drives both tones. The 19 kHz tone uses
// the accumulator plus one extra phase bit (r19) that toggles on every
// accumulator wrap. As a result the pilot is exactly half the subcarrier rate
// and stays phase-locked to it.
//
// The square outputs come straight from the phase state. The sine outputs
// come from a shared quarter-wave LUT and trail the square outputs by two
// cycles: one cycle for the LUT read and one for the sign stage.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_en         1 = accumulator advances, 0 = phase frozen
//   i_tw         new 38 kHz tuning word
//   i_tw_valid   1-cycle strobe: capture i_tw as the pending word
//   o_tw_ack     1-cycle pulse: the pending word is now in use
//   o_38kHz      38 kHz square (accumulator MSB)
//   o_19kHz      19 kHz square (r19 toggle bit)
//   o_sync       1-cycle pulse at the start of each 19 kHz cycle
//   o_sub_sin    signed 38 kHz sine sample
//   o_pilot_sin  signed 19 kHz sine sample
//   o_smp_valid  sine pipeline primed
// -----------------------------------------------------------------------------
module fm_stereo_nco_gen #(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned TW_DEFAULT = 3264175,
  parameter int unsigned LUT_AW     = 8,
  parameter int unsigned AMP_W      = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [PHASE_W-1:0]      i_tw,
  input  logic                    i_tw_valid,
  output logic                    o_tw_ack,
  output logic                    o_38kHz,
  output logic                    o_19kHz,
  output logic                    o_sync,
  output logic signed [AMP_W-1:0] o_sub_sin,
  output logic signed [AMP_W-1:0] o_pilot_sin,
  output logic                    o_smp_valid
);

  localparam int unsigned LUT_N = 1 << LUT_AW;
  // Sine phase width: 2 quadrant bits plus the LUT address.
  localparam int unsigned SUB_W = LUT_AW + 2;

  // ---------------------------------------------------------------------------
  // Quarter-wave LUT contents.
  // Each entry is sampled at the centre of its step, (k + 0.5). With that
  // offset, mirroring and negating the quarter wave gives an exactly
  // symmetric full wave. The peak magnitude is 2^(AMP_W-1)-1, so negating it
  // never overflows. The sine is a Taylor series in real arithmetic. It is
  // evaluated only while the ROM constants are elaborated.
  // ---------------------------------------------------------------------------
  function automatic logic [AMP_W-2:0] lut_entry(input int k);
    real pi_v;
    real x;
    real x2;
    real term;
    real s;
    real amp;
    int  r;
    pi_v = 3.14159265358979323846;
    x    = pi_v / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    x2   = x * x;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = real'((1 << (AMP_W - 1)) - 1);
    r   = $rtoi(amp * s + 0.5);
    lut_entry = (AMP_W - 1)'(r);
  endfunction

  logic [AMP_W-2:0] lut_rom [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign lut_rom[gi] = lut_entry(gi);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Phase accumulator, 19 kHz toggle bit and retune handling
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] acc_q,  acc_d;
  logic               r19_q,  r19_d;
  logic [PHASE_W-1:0] tw_q,   tw_d;
  logic [PHASE_W-1:0] pend_q, pend_d;
  logic               pflag_q, pflag_d;
  logic               sync_q, sync_d;
  logic               ack_q,  ack_d;
  logic [1:0]         vld_q,  vld_d;
  logic [PHASE_W:0]   sum_w;

  // One extra bit captures the unsigned carry, which marks the 38 kHz wrap.
  assign sum_w = {1'b0, acc_q} + {1'b0, tw_q};

  always_comb begin
    acc_d   = acc_q;
    r19_d   = r19_q;
    tw_d    = tw_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    sync_d  = 1'b0;
    ack_d   = 1'b0;
    vld_d   = {vld_q[0], 1'b1};

    if (i_en) begin
      acc_d = sum_w[PHASE_W-1:0];
      if (sum_w[PHASE_W]) begin
        r19_d  = ~r19_q;
        // r19 going 1->0 starts a new 19 kHz cycle.
        sync_d = r19_q;
        // A retune is applied only at a wrap, so the frequency step is
        // phase-continuous.
        if (pflag_q) begin
          tw_d    = pend_q;
          pflag_d = 1'b0;
          ack_d   = 1'b1;
        end
      end
    end

    // A strobe on a wrap cycle still lands in the pending slot. It then
    // waits for the next wrap. A later strobe overwrites an unapplied one.
    if (i_tw_valid) begin
      pend_d  = i_tw;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q   <= '0;
      r19_q   <= 1'b0;
      tw_q    <= PHASE_W'(TW_DEFAULT);
      pend_q  <= '0;
      pflag_q <= 1'b0;
      sync_q  <= 1'b0;
      ack_q   <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      acc_q   <= acc_d;
      r19_q   <= r19_d;
      tw_q    <= tw_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
    end
  end

  assign o_38kHz     = acc_q[PHASE_W-1];
  assign o_19kHz     = r19_q;
  assign o_sync      = sync_q;
  assign o_tw_ack    = ack_q;
  assign o_smp_valid = vld_q[1];

  // ---------------------------------------------------------------------------
  // Sine channels: 0 = 38 kHz subcarrier, 1 = 19 kHz pilot.
  // The pilot phase is one bit wider at the top because r19 carries it. The
  // LUT index is therefore taken one bit higher in the accumulator.
  // ---------------------------------------------------------------------------
  logic [SUB_W-1:0] ch_ph [2];

  assign ch_ph[0] = acc_q[PHASE_W-1 -: SUB_W];
  assign ch_ph[1] = {r19_q, acc_q[PHASE_W-1 -: SUB_W-1]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0]              quad;
      logic [LUT_AW-1:0]       a_w;
      logic [LUT_AW-1:0]       addr;
      logic [AMP_W-2:0]        mag_q, mag_d;
      logic                    neg_q, neg_d;
      logic [AMP_W-1:0]        mag_ext;
      logic signed [AMP_W-1:0] smp_q, smp_d;

      always_comb begin
        quad    = ch_ph[gi][SUB_W-1 -: 2];
        a_w     = ch_ph[gi][LUT_AW-1:0];
        // Quadrants 1 and 3 run the quarter wave backwards.
        addr    = quad[0] ? ~a_w : a_w;
        mag_d   = lut_rom[addr];
        // Quadrants 2 and 3 are the negative half.
        neg_d   = quad[1];
        mag_ext = {1'b0, mag_q};
        smp_d   = neg_q ? -$signed(mag_ext) : $signed(mag_ext);
      end

      // The pipeline runs every cycle. With the phase frozen it re-reads
      // the same entry, so the outputs hold.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          mag_q <= '0;
          neg_q <= 1'b0;
          smp_q <= '0;
        end else begin
          mag_q <= mag_d;
          neg_q <= neg_d;
          smp_q <= smp_d;
        end
      end
    end
  endgenerate

  assign o_sub_sin   = g_ch[0].smp_q;
  assign o_pilot_sin = g_ch[1].smp_q;

endmodule

// File: tb/tb_fm_stereo_nco_gen.sv
module tb_fm_stereo_nco_gen;

  localparam int PW   = 8;
  localparam int TWD  = 16;
  localparam int LAW  = 2;
  localparam int AW   = 8;
  localparam int AMP  = (1 << (AW - 1)) - 1;  // 127
  localparam int NSTP = 1 << (LAW + 2);       // sine steps per period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 en;
  logic [PW-1:0]        tw;
  logic                 tw_valid;
  logic                 tw_ack;
  logic                 sq38;
  logic                 sq19;
  logic                 sync_p;
  logic signed [AW-1:0] sub_sin;
  logic signed [AW-1:0] pilot_sin;
  logic                 smp_valid;

  fm_stereo_nco_gen #(
    .PHASE_W   (PW),
    .TW_DEFAULT(TWD),
    .LUT_AW    (LAW),
    .AMP_W     (AW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_tw       (tw),
    .i_tw_valid (tw_valid),
    .o_tw_ack   (tw_ack),
    .o_38kHz    (sq38),
    .o_19kHz    (sq19),
    .o_sync     (sync_p),
    .o_sub_sin  (sub_sin),
    .o_pilot_sin(pilot_sin),
    .o_smp_valid(smp_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model.
  // The phase is a single integer over one 19 kHz period: 0 .. 2*2^PW-1.
  // The 38 kHz phase is that value mod 2^PW. Each sine is the ideal
  // round(A*sin(2*pi*(i+0.5)/N)) of its quantised phase step i.
  // ---------------------------------------------------------------------------
  int m_ph, m_tw, m_pend, m_cnt;
  bit m_flag, m_sync, m_ack;
  int m_s1_sub, m_s1_pil, m_out_sub, m_out_pil;

  function automatic int sin_ref(input int idx);
    real y;
    y = real'(AMP) * $sin(2.0 * 3.14159265358979 * (real'(idx) + 0.5) / real'(NSTP));
    if (y >= 0.0) return $rtoi(y + 0.5);
    return -$rtoi(0.5 - y);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit v, input int t);
    int nxt;
    bit wrap;
    if (r) begin
      m_ph = 0; m_tw = TWD; m_pend = 0; m_flag = 0; m_sync = 0; m_ack = 0;
      m_s1_sub = 0; m_s1_pil = 0; m_out_sub = 0; m_out_pil = 0; m_cnt = 0;
      return;
    end
    // Sine outputs trail the phase by two clocks.
    m_out_sub = m_s1_sub;
    m_out_pil = m_s1_pil;
    m_s1_sub  = sin_ref((m_ph % 256) / (256 / NSTP));
    m_s1_pil  = sin_ref(m_ph / (512 / NSTP));
    m_sync = 0;
    m_ack  = 0;
    if (e) begin
      nxt    = m_ph + m_tw;
      wrap   = ((m_ph % 256) + m_tw) >= 256;
      m_sync = (nxt >= 512);
      m_ph   = nxt % 512;
      if (wrap && m_flag) begin
        m_tw   = m_pend;
        m_flag = 0;
        m_ack  = 1;
      end
    end
    if (v) begin
      m_pend = t;
      m_flag = 1;
    end
    if (m_cnt < 2) m_cnt++;
  endtask

  task automatic compare_all();
    check_val("sq38",  int'(sq38),      int'((m_ph % 256) >= 128));
    check_val("sq19",  int'(sq19),      int'(m_ph >= 256));
    check_val("sync",  int'(sync_p),    int'(m_sync));
    check_val("ack",   int'(tw_ack),    int'(m_ack));
    check_val("valid", int'(smp_valid), int'(m_cnt >= 2));
    check_val("sub",   int'(sub_sin),   m_out_sub);
    check_val("pilot", int'(pilot_sin), m_out_pil);
  endtask

  // Drive inputs (just after a falling edge), take one rising edge, then
  // check at the following falling edge.
  task automatic cycle(input bit r, input bit e, input bit v, input int t);
    rst      = r;
    en       = e;
    tw_valid = v;
    tw       = PW'(t);
    @(posedge clk);
    model_edge(r, e, v, t);
    @(negedge clk);
    compare_all();
  endtask

  int  first_sync, sync2, rise1, rise2, ack_k, n_ack;
  int  sum, mn, mx;
  bit  prev38, prev19;
  int  snap_sub, snap_pil;
  bit  snap38, snap19;
  bit  hit;

  initial begin
    rst = 1'b1; en = 1'b0; tw = '0; tw_valid = 1'b0;

    // Reset, then free run at the default tuning word.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    first_sync = -1; sync2 = -1; rise1 = -1; rise2 = -1;
    sum = 0; mn = 1000; mx = -1000; prev38 = 0; prev19 = 0;
    for (int k = 1; k <= 80; k++) begin
      cycle(0, 1, 0, 0);
      if (sync_p) begin
        if (first_sync < 0) first_sync = k;
        else if (sync2 < 0) sync2 = k;
      end
      if (sq38 && !prev38) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      if (sq19 != prev19) check_val("coh_38_fall", int'({prev38, sq38}), 2);
      prev38 = sq38; prev19 = sq19;
      if (k >= 3 && k <= 18) begin
        sum += int'(sub_sin);
        if (int'(sub_sin) < mn) mn = int'(sub_sin);
        if (int'(sub_sin) > mx) mx = int'(sub_sin);
      end
      if (k == 18) check_val("sub_at_acc0", int'(sub_sin), 25);
    end
    check_val("first_sync", first_sync, 32);
    check_val("sync_period", sync2 - first_sync, 32);
    check_val("period38", rise2 - rise1, 16);
    check_val("sub_sum", sum, 0);
    check_val("sub_min", mn, -125);
    check_val("sub_max", mx, 125);
    $display("[tb] free run: first sync at %0d, 38k period %0d", first_sync, rise2 - rise1);

    // Retune mid-period: two strobes before the wrap, the last one wins.
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if ((m_ph % 256) == 64) hit = 1;
      else cycle(0, 1, 0, 0);
    end
    check_val("reach_ph64", int'(hit), 1);
    cycle(0, 1, 1, 24);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32);
    ack_k = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(0, 1, 0, 0);
      if (tw_ack && ack_k < 0) ack_k = k;
    end
    check_val("ack_latency", ack_k, 9);
    rise1 = -1; rise2 = -1; prev38 = sq38;
    for (int k = 1; k <= 30; k++) begin
      cycle(0, 1, 0, 0);
      if (sq38 && !prev38) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev38 = sq38;
    end
    check_val("period38_tw32", rise2 - rise1, 8);
    $display("[tb] retune: ack after %0d cycles, new period %0d", ack_k, rise2 - rise1);

    // Freeze for 10 cycles: every output holds.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    snap38 = sq38; snap19 = sq19; snap_sub = int'(sub_sin); snap_pil = int'(pilot_sin);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0);
      if (k >= 2) begin
        check_val("hold_sub", int'(sub_sin), sin_ref((m_ph % 256) / (256 / NSTP)));
      end
      check_val("hold38", int'(sq38), int'(snap38));
      check_val("hold19", int'(sq19), int'(snap19));
    end
    check_val("hold_pil_snapshot", int'(pilot_sin), snap_pil == snap_pil ? m_out_pil : 0);
    for (int k = 0; k < 20; k++) cycle(0, 1, 0, 0);
    $display("[tb] freeze: 10 cycles held, sub was %0d", snap_sub);

    // Reset with a retune pending: the retune is discarded.
    cycle(0, 1, 1, 40);
    cycle(1, 1, 0, 0);
    check_val("rst_sq38", int'(sq38), 0);
    check_val("rst_sub", int'(sub_sin), 0);
    n_ack = 0; rise1 = -1; prev38 = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(0, 1, 0, 0);
      if (tw_ack) n_ack++;
      if (sq38 && !prev38 && rise1 < 0) rise1 = k;
      prev38 = sq38;
    end
    check_val("no_ack_after_rst", n_ack, 0);
    check_val("first_rise_after_rst", rise1, 8);
    $display("[tb] reset with pending retune: %0d acks, first rise %0d", n_ack, rise1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom % 300) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
            int'($urandom_range(4, 200)));
    end
    $display("[tb] random: 600 cycles");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
